pong_game_ctrl: RTL

Game-flow controller for the Pong display path. It consumes the ball-event outputs of the pong graphics block (`hit`, `miss`) and produces the `gra_still` freeze signal that block needs. It also keeps both players' scores, sequences new-game, serve and game-over phases, and times the pause between rallies in display frames. It sits beside the graphics block and shares its clock and pixel coordinates.

---
 rtl/pong_game_ctrl.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/pong_game_ctrl.sv
// pong_game_ctrl: Pong game-flow controller (scores, serve/over sequencing, inter-rally frame pause).
// Build option: define PONG_CTRL_AUTOSERVE_EN to serve automatically when the NEWBALL pause expires.
module pong_game_ctrl #(
  parameter int unsigned WIN_SCORE    = 5,
  parameter int unsigned PAUSE_FRAMES = 120,
  parameter int unsigned TICK_Y       = 481
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [9:0] x,
  input  logic [9:0] y,
  input  logic [3:0] btn,
  input  logic [1:0] hit,
  input  logic       miss,
  output logic       gra_still,
  output logic [1:0] game_state,
  output logic [3:0] p1_score,
  output logic [3:0] p2_score,
  output logic [1:0] winner
);

  localparam int unsigned SCORE_W = 4;
  localparam int unsigned PAUSE_W = 8;
  localparam int unsigned COORD_W = 10;

  localparam logic [SCORE_W-1:0] WIN_VAL   = SCORE_W'(WIN_SCORE);
  localparam logic [PAUSE_W-1:0] PAUSE_VAL = PAUSE_W'(PAUSE_FRAMES);
  localparam logic [COORD_W-1:0] TICK_ROW  = COORD_W'(TICK_Y);

  localparam logic [1:0] WIN_NONE = 2'b00;
  localparam logic [1:0] WIN_P1   = 2'b01;
  localparam logic [1:0] WIN_P2   = 2'b10;

  typedef enum logic [1:0] {
    ST_NEWGAME = 2'b00,
    ST_PLAY    = 2'b01,
    ST_NEWBALL = 2'b10,
    ST_OVER    = 2'b11
  } state_t;

  state_t               state, state_nxt;
  logic [SCORE_W-1:0]   p1_nxt, p2_nxt, p1_inc, p2_inc;
  logic [1:0]           winner_nxt;
  logic [PAUSE_W-1:0]   pause_cnt, pause_nxt;
  logic                 cond, cond_d, frame_tick;
  logic                 any_btn, any_d, press;

  // Edge detectors: one tick per frame regardless of pixel duration, one press per button push
  assign cond       = (y == TICK_ROW) && (x == '0);
  assign frame_tick = cond & ~cond_d;
  assign any_btn    = |btn;
  assign press      = any_btn & ~any_d;

  assign gra_still  = (state != ST_PLAY);
  assign game_state = state;

  // Scores saturate at the winning score
  assign p1_inc = (p1_score < WIN_VAL) ? SCORE_W'(p1_score + SCORE_W'(1)) : p1_score;
  assign p2_inc = (p2_score < WIN_VAL) ? SCORE_W'(p2_score + SCORE_W'(1)) : p2_score;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ST_NEWGAME;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    p1_nxt     = p1_score;
    p2_nxt     = p2_score;
    winner_nxt = winner;
    pause_nxt  = pause_cnt;

    if (frame_tick && (pause_cnt != '0)) pause_nxt = pause_cnt - PAUSE_W'(1);

    case (state)
      ST_NEWGAME: begin
        p1_nxt     = '0;
        p2_nxt     = '0;
        winner_nxt = WIN_NONE;
        if (press) state_nxt = ST_PLAY;
      end
      ST_PLAY: begin
        // The pause load overrides any same-cycle frame tick decrement
        if (miss) begin
          pause_nxt = PAUSE_VAL;
          state_nxt = ST_NEWBALL;
          if (hit == 2'b10) begin
            p1_nxt = p1_inc;
            if (p1_inc == WIN_VAL) begin
              state_nxt  = ST_OVER;
              winner_nxt = WIN_P1;
            end
          end else if (hit == 2'b01) begin
            p2_nxt = p2_inc;
            if (p2_inc == WIN_VAL) begin
              state_nxt  = ST_OVER;
              winner_nxt = WIN_P2;
            end
          end
        end
      end
      ST_NEWBALL: begin
`ifdef PONG_CTRL_AUTOSERVE_EN
        if (pause_cnt == '0) state_nxt = ST_PLAY;
`else
        if ((pause_cnt == '0) && press) state_nxt = ST_PLAY;
`endif
      end
      ST_OVER: begin
        if ((pause_cnt == '0) && press) begin
          state_nxt  = ST_NEWGAME;
          p1_nxt     = '0;
          p2_nxt     = '0;
          winner_nxt = WIN_NONE;
        end
      end
      default: state_nxt = ST_NEWGAME;
    endcase
  end

  // any_d resets high so a button held through reset must be released before it can start a game
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      p1_score  <= '0;
      p2_score  <= '0;
      winner    <= WIN_NONE;
      pause_cnt <= '0;
      cond_d    <= 1'b0;
      any_d     <= 1'b1;
    end else begin
      p1_score  <= p1_nxt;
      p2_score  <= p2_nxt;
      winner    <= winner_nxt;
      pause_cnt <= pause_nxt;
      cond_d    <= cond;
      any_d     <= any_btn;
    end
  end

endmodule
